pipe_stage_reg: RTL and testbench

// - Generic pipeline stage register with valid/ready handshake, replacing fixed-field stage regs (ex->mem, mem->wb).
// - Carries opaque payload plus GPR write-back control (active-low we_, dst addr).
// - Adds stall, flush and backpressure behaviour, and a saturating backpressure counter.
// - Optional 2-entry skid buffer breaks the combinational ready path.

---
 rtl/pipe_stage_reg_pkg.sv | 15 +
 rtl/pipe_stage_reg_if.sv | 32 +++
 rtl/pipe_skid_buf.sv | 113 +++++++++++
 rtl/pipe_stage_reg.sv | 87 ++++++++
 tb/tb_pipe_stage_reg.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and skid-buffer state encoding for pipe_stage_reg.
// Imported by the interface, the skid buffer and the stage top.
package pipe_stage_reg_pkg;

  localparam int PIPE_PAYLOAD_W = 96;
  localparam int GPR_ADDR_W     = 5;
  localparam int PIPE_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_st_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle carrying payload plus GPR write-back control.
// master drives the entry, slave returns ready.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int DST_W     = GPR_ADDR_W
);

  logic                 valid;
  logic                 ready;
  logic [PAYLOAD_W-1:0] payload;
  logic                 gpr_we_;
  logic [DST_W-1:0]     dst_addr;

  modport master (
    output valid,
    output payload,
    output gpr_we_,
    output dst_addr,
    input  ready
  );

  modport slave (
    input  valid,
    input  payload,
    input  gpr_we_,
    input  dst_addr,
    output ready
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry FIFO storage + EMPTY/ONE/TWO FSM for pipe_stage_reg.
// Only built when PIPE_SKID_EN is defined; in_ready is registered-state only.
`ifdef PIPE_SKID_EN
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int DST_W     = GPR_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_gpr_we_,
  input  logic [DST_W-1:0]     in_dst_addr,
  input  logic                 out_ready,
  output logic                 in_ready,
  output logic                 head_valid,
  output logic [PAYLOAD_W-1:0] head_payload,
  output logic                 head_gpr_we_,
  output logic [DST_W-1:0]     head_dst_addr
);

  pipe_st_e st, st_nx;
  logic acc, drn;
  logic ld_head_in, ld_head_skid, ld_skid;

  logic [PAYLOAD_W-1:0] sk_payload;
  logic                 sk_gpr_we_;
  logic [DST_W-1:0]     sk_dst_addr;

  assign head_valid = (st != ST_EMPTY);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= ST_EMPTY;
    else        st <= st_nx;
  end

  // next state and storage load selects
  always_comb begin
    st_nx        = st;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    in_ready     = ~stall & (st != ST_TWO);
    acc          = in_valid & in_ready;
    drn          = (st != ST_EMPTY) & out_ready & ~stall;
    if (flush) begin
      st_nx = ST_EMPTY;
    end else begin
      case (st)
        ST_EMPTY: begin
          if (acc) begin
            st_nx      = ST_ONE;
            ld_head_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            ld_head_in = 1'b1;
          end else if (acc) begin
            st_nx   = ST_TWO;
            ld_skid = 1'b1;
          end else if (drn) begin
            st_nx = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drn) begin
            st_nx        = ST_ONE;
            ld_head_skid = 1'b1;
          end
        end
        default: st_nx = ST_EMPTY;
      endcase
    end
  end

  // head slot: oldest entry, refilled from input or skid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_payload  <= '0;
      head_gpr_we_  <= 1'b1;
      head_dst_addr <= '0;
    end else if (ld_head_in) begin
      head_payload  <= in_payload;
      head_gpr_we_  <= in_gpr_we_;
      head_dst_addr <= in_dst_addr;
    end else if (ld_head_skid) begin
      head_payload  <= sk_payload;
      head_gpr_we_  <= sk_gpr_we_;
      head_dst_addr <= sk_dst_addr;
    end
  end

  // skid slot: second-oldest entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sk_payload  <= '0;
      sk_gpr_we_  <= 1'b1;
      sk_dst_addr <= '0;
    end else if (ld_skid) begin
      sk_payload  <= in_payload;
      sk_gpr_we_  <= in_gpr_we_;
      sk_dst_addr <= in_dst_addr;
    end
  end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall/flush.
// Macro PIPE_SKID_EN selects 2-entry skid buffer over single slot.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int DST_W     = GPR_ADDR_W,
  parameter int CNT_W     = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] bp_cycles
);

  logic                 in_rdy;
  logic                 hv;
  logic [PAYLOAD_W-1:0] hp;
  logic                 hwe;
  logic [DST_W-1:0]     hd;

`ifdef PIPE_SKID_EN
  pipe_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W),
    .DST_W     (DST_W)
  ) u_skid (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (up.valid),
    .in_payload    (up.payload),
    .in_gpr_we_    (up.gpr_we_),
    .in_dst_addr   (up.dst_addr),
    .out_ready     (dn.ready),
    .in_ready      (in_rdy),
    .head_valid    (hv),
    .head_payload  (hp),
    .head_gpr_we_  (hwe),
    .head_dst_addr (hd)
  );
`else
  logic acc;

  assign in_rdy = ~stall & (~hv | dn.ready);
  assign acc    = up.valid & in_rdy;

  // slot valid: refill on accept, empty on drain-only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                hv <= 1'b0;
    else if (flush)            hv <= 1'b0;
    else if (acc)              hv <= 1'b1;
    else if (!stall && dn.ready) hv <= 1'b0;
  end

  // slot data: loads only on a kept accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hp  <= '0;
      hwe <= 1'b1;
      hd  <= '0;
    end else if (acc && !flush) begin
      hp  <= up.payload;
      hwe <= up.gpr_we_;
      hd  <= up.dst_addr;
    end
  end
`endif

  assign up.ready    = in_rdy;
  assign dn.valid    = hv & ~stall;
  assign dn.payload  = hp;
  assign dn.dst_addr = hd;
  assign dn.gpr_we_  = hwe | ~dn.valid;

  // saturating count of cycles a valid head waits on downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bp_cycles <= '0;
    else if (hv && !dn.ready && !stall && (bp_cycles != '1))
      bp_cycles <= bp_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg with a queue-based model.
// Works in both builds (PIPE_SKID_EN defined or not).
module tb_pipe_stage_reg;

  localparam int PW = 96;
  localparam int DW = 5;
  localparam int CW = 4;
  localparam int BP_MAX = 15;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [PW-1:0] p;
    logic          we;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] bp_cycles;

  pipe_stage_reg_if #(.PAYLOAD_W(PW), .DST_W(DW)) up_if ();
  pipe_stage_reg_if #(.PAYLOAD_W(PW), .DST_W(DW)) dn_if ();

  pipe_stage_reg #(
    .PAYLOAD_W (PW),
    .DST_W     (DW),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .stall     (stall),
    .flush     (flush),
    .bp_cycles (bp_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  ent_t q[$];
  int   m_bp = 0;

  function automatic logic m_ready();
    if (stall) return 1'b0;
    if (q.size() < DEPTH) return 1'b1;
    return (DEPTH == 1) && dn_if.ready;
  endfunction

  function automatic logic m_ov();
    return (q.size() > 0) && !stall;
  endfunction

  task automatic set_in(input logic v, input logic [PW-1:0] p,
                        input logic we, input logic [DW-1:0] d,
                        input logic st, input logic fl,
                        input logic ordy);
    up_if.valid    = v;
    up_if.payload  = p;
    up_if.gpr_we_  = we;
    up_if.dst_addr = d;
    stall          = st;
    flush          = fl;
    dn_if.ready    = ordy;
  endtask

  task automatic idle(input logic ordy);
    set_in(1'b0, '0, 1'b1, '0, 1'b0, 1'b0, ordy);
  endtask

  // advance one clock and update the reference model
  task automatic tick();
    logic rdy, drn, acc;
    ent_t e;
    rdy = m_ready();
    drn = (q.size() > 0) && dn_if.ready && !stall;
    acc = up_if.valid && rdy;
    e.p = up_if.payload;
    e.we = up_if.gpr_we_;
    e.d = up_if.dst_addr;
    if ((q.size() > 0) && !dn_if.ready && !stall && (m_bp < BP_MAX))
      m_bp++;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(1'b0);
    reset = 1'b0;
    #1;
    q.delete();
    m_bp = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle(1'b0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (dn_if.valid !== 1'b0 || dn_if.gpr_we_ !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctrl: valid=%b we_=%b want 0/1",
               dn_if.valid, dn_if.gpr_we_);
    end
    total++;
    if (dn_if.payload !== '0 || dn_if.dst_addr !== '0 || bp_cycles !== '0) begin
      bad++;
      $display("FAIL reset_data: pl=%h dst=%h bp=%0d want 0",
               dn_if.payload, dn_if.dst_addr, bp_cycles);
    end
    reset = 1'b1;
    @(negedge clk);
    set_in(1'b1, 96'hAB, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    tick();
    #1;
    total++;
    if (dn_if.valid !== 1'b1 || bp_cycles !== 4'd1) begin
      bad++;
      $display("FAIL reset_pre: valid=%b bp=%0d want 1/1",
               dn_if.valid, bp_cycles);
    end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (dn_if.valid !== 1'b0 || dn_if.gpr_we_ !== 1'b1 || bp_cycles !== '0) begin
      bad++;
      $display("FAIL reset_async: valid=%b we_=%b bp=%0d want 0/1/0",
               dn_if.valid, dn_if.gpr_we_, bp_cycles);
    end
    q.delete();
    m_bp = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, PW'(i), 1'b0, DW'(i), 1'b0, 1'b0, 1'b1);
      #1;
      total++;
      if (up_if.ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_rdy%0d: got %b want 1", i, up_if.ready);
      end
      if (i > 1) begin
        total++;
        if (dn_if.valid !== 1'b1 || dn_if.payload !== PW'(i - 1)) begin
          bad++;
          $display("FAIL stream_out%0d: valid=%b pl=%0h want 1/%0h",
                   i, dn_if.valid, dn_if.payload, i - 1);
        end
      end
      tick();
    end
    idle(1'b1);
    #1;
    total++;
    if (dn_if.valid !== 1'b1 || dn_if.payload !== PW'(3)) begin
      bad++;
      $display("FAIL stream_last: valid=%b pl=%0h want 1/3",
               dn_if.valid, dn_if.payload);
    end
    tick();
    #1;
    total++;
    if (dn_if.valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_empty: valid=%b want 0", dn_if.valid);
    end
  endtask

  task automatic test_backpressure();
    int n_acc;
    do_reset();
    n_acc = 0;
    set_in(1'b1, 96'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
    #1;
    if (up_if.valid && up_if.ready) n_acc++;
    tick();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, PW'(32 + k), 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (dn_if.valid !== 1'b1 || dn_if.payload !== PW'(17)) begin
        bad++;
        $display("FAIL bp_head%0d: valid=%b pl=%0h want 1/11",
                 k, dn_if.valid, dn_if.payload);
      end
      total++;
      if (up_if.ready !== (k < DEPTH - 1)) begin
        bad++;
        $display("FAIL bp_rdy%0d: got %b want %b",
                 k, up_if.ready, (k < DEPTH - 1));
      end
      if (up_if.valid && up_if.ready) n_acc++;
      tick();
    end
    idle(1'b1);
    #1;
    total++;
    if (bp_cycles !== 4'd4) begin
      bad++;
      $display("FAIL bp_count: got %0d want 4", bp_cycles);
    end
    total++;
    if (n_acc !== DEPTH) begin
      bad++;
      $display("FAIL bp_accepts: got %0d want %0d", n_acc, DEPTH);
    end
    tick();
    if (DEPTH == 2) begin
      #1;
      total++;
      if (dn_if.valid !== 1'b1 || dn_if.payload !== PW'(32)) begin
        bad++;
        $display("FAIL bp_order: valid=%b pl=%0h want 1/20",
                 dn_if.valid, dn_if.payload);
      end
      tick();
    end
    #1;
    total++;
    if (dn_if.valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drained: valid=%b want 0", dn_if.valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, 96'h55, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 96'h66, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
    #1;
    total++;
    if (dn_if.valid !== 1'b1 || dn_if.dst_addr !== 5'd5 || dn_if.gpr_we_ !== 1'b0) begin
      bad++;
      $display("FAIL flush_pre: valid=%b dst=%0d we_=%b want 1/5/0",
               dn_if.valid, dn_if.dst_addr, dn_if.gpr_we_);
    end
    tick();
    idle(1'b1);
    #1;
    total++;
    if (dn_if.valid !== 1'b0 || dn_if.gpr_we_ !== 1'b1) begin
      bad++;
      $display("FAIL flush_kill: valid=%b we_=%b want 0/1",
               dn_if.valid, dn_if.gpr_we_);
    end
    tick();
    #1;
    total++;
    if (dn_if.valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_lost: valid=%b want 0", dn_if.valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1'b1, 96'h77, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 96'h88, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
      #1;
      total++;
      if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b0 || dn_if.gpr_we_ !== 1'b1) begin
        bad++;
        $display("FAIL stall_mask%0d: valid=%b rdy=%b we_=%b want 0/0/1",
                 k, dn_if.valid, up_if.ready, dn_if.gpr_we_);
      end
      tick();
    end
    idle(1'b0);
    #1;
    total++;
    if (bp_cycles !== 4'd0) begin
      bad++;
      $display("FAIL stall_bp: got %0d want 0", bp_cycles);
    end
    total++;
    if (dn_if.valid !== 1'b1 || dn_if.payload !== PW'(119) || dn_if.dst_addr !== 5'd9) begin
      bad++;
      $display("FAIL stall_keep: valid=%b pl=%0h dst=%0d want 1/77/9",
               dn_if.valid, dn_if.payload, dn_if.dst_addr);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(1'b1, 96'h99, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    for (int k = 0; k < 20; k++) tick();
    #1;
    total++;
    if (bp_cycles !== 4'd15) begin
      bad++;
      $display("FAIL sat_count: got %0d want 15", bp_cycles);
    end
  endtask

  task automatic test_random();
    logic exp_ov, exp_we;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 3) != 0),
             {$urandom, $urandom, $urandom},
             1'($urandom), 5'($urandom),
             1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 2) != 0));
      #1;
      exp_ov = m_ov();
      exp_we = exp_ov ? q[0].we : 1'b1;
      total++;
      if (up_if.ready !== m_ready() || dn_if.valid !== exp_ov ||
          dn_if.gpr_we_ !== exp_we || bp_cycles !== CW'(m_bp)) begin
        bad++;
        $display("FAIL rnd_ctrl c=%0d: rdy=%b ov=%b we_=%b bp=%0d want %b/%b/%b/%0d",
                 c, up_if.ready, dn_if.valid, dn_if.gpr_we_, bp_cycles,
                 m_ready(), exp_ov, exp_we, m_bp);
      end
      if (exp_ov) begin
        total++;
        if (dn_if.payload !== q[0].p || dn_if.dst_addr !== q[0].d) begin
          bad++;
          $display("FAIL rnd_data c=%0d: pl=%h dst=%0d want %h/%0d",
                   c, dn_if.payload, dn_if.dst_addr, q[0].p, q[0].d);
        end
      end
      tick();
    end
  endtask

  initial begin
    idle(1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
